sd_fifo_cmt: RTL and testbench
==============================

SD_FIFO_CMT -- requirements
Module: sd_fifo_cmt

Interface
REQ-001 SHALL have parameter width, default 8, data bits per entry.
REQ-002 SHALL have parameter depth, default 12, entry count; any integer >= 2, power of 2 not required.
REQ-003 SHALL have parameter commit_mode, default 1; 1 = commit/abort active, 0 = every accepted write commits immediately and c_commit/c_abort are ignored.
REQ-004 SHALL have parameter af_level, default depth-2, almost-full threshold, range 1..depth.
REQ-005 SHALL have parameter ae_level, default 1, almost-empty threshold, range 0..depth-1.
REQ-006 SHALL have derived parameter usz = $clog2(depth+1), usage width.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 reset_n  input  1  reset, asynchronous, active-low.
REQ-009 c_srdy  input  1  producer-side write valid.
REQ-010 c_drdy  output  1  FIFO can accept a write.
REQ-011 c_data  input  width  write data.
REQ-012 c_commit  input  1  make all uncommitted entries readable.
REQ-013 c_abort  input  1  discard all uncommitted entries.
REQ-014 c_usage  output  usz  total entries held, committed plus uncommitted.
REQ-015 almost_full  output  1  c_usage >= af_level.
REQ-016 p_srdy  output  1  committed entry available.
REQ-017 p_drdy  input  1  consumer accepts entry.
REQ-018 p_data  output  width  entry at read pointer; valid only while p_srdy=1.
REQ-019 p_usage  output  usz  committed entries readable.
REQ-020 almost_empty  output  1  p_usage <= ae_level.

Function
REQ-021 SHALL keep three pointers, each 0..depth-1, wrapping depth-1 -> 0: wr_ptr (next write), cmt_ptr (commit boundary), rd_ptr (next read).
REQ-022 SHALL keep registered counts c_usage and p_usage; pointer equality alone SHALL NOT determine full/empty.
REQ-023 Write occurs when c_srdy & c_drdy; stores c_data at wr_ptr, advances wr_ptr.
REQ-024 c_drdy SHALL equal (c_usage < depth), with no combinational dependency on c_srdy, p_drdy, c_commit or c_abort.
REQ-025 Read occurs when p_srdy & p_drdy; advances rd_ptr; p_srdy SHALL equal (p_usage != 0).
REQ-026 p_data SHALL be a combinational read of the storage array at rd_ptr; no read latency.
REQ-027 c_commit in cycle N: cmt_ptr <= wr_ptr after any write in cycle N, so a word written in the same cycle is included.
REQ-028 c_abort in cycle N: wr_ptr <= cmt_ptr; any write in cycle N is discarded; c_usage drops by the uncommitted count.
REQ-029 c_commit and c_abort together: abort wins, commit ignored.
REQ-030 Commit and abort SHALL be honoured without c_srdy and while c_drdy=0, so a FIFO full of uncommitted data can always be released or flushed.
REQ-031 Committed data SHALL appear as p_srdy=1 at cycle N+1 for a commit at cycle N; p_usage increases by the committed count in the same edge.
REQ-032 Simultaneous read and write/commit: counts update by net change; a read in the same cycle as a full-state write frees its slot only at the next edge (c_drdy stays 0 that cycle).
REQ-033 commit_mode=0: cmt_ptr tracks wr_ptr every write; a write at N is readable at N+1.
REQ-034 Reads SHALL never pass cmt_ptr; aborts SHALL never move wr_ptr behind cmt_ptr.
REQ-035 almost_full and almost_empty SHALL be combinational from the registered counts only.

Reset
REQ-036 reset_n low SHALL asynchronously clear wr_ptr, cmt_ptr, rd_ptr, c_usage, p_usage.
REQ-037 During and after reset: c_drdy=1, p_srdy=0, c_usage=0, p_usage=0, almost_full=0, almost_empty=1; storage array is not reset.
REQ-038 Reset asserted mid-packet SHALL discard all entries, committed or not.

Verification
REQ-039 depth=12, commit_mode=1: write 5 words, no commit -> p_srdy=0, c_usage=5, p_usage=0; commit at cycle N -> p_srdy=1 at N+1, p_usage=5.
REQ-040 Write 3 and commit; write 4 more, abort together with a 5th write -> c_usage=3, p_usage=3; readout returns only the first 3 words in order.
REQ-041 Fill 12 uncommitted -> c_drdy=0, almost_full=1; commit with c_srdy=0 -> p_usage=12; read 1 -> c_drdy=1 next cycle.
REQ-042 Stream 40 words with commit every 4, reading concurrently -> data in order across multiple wraps at index 11->0, no loss or duplication.
REQ-043 commit_mode=0, c_commit/c_abort toggled randomly -> every written word readable one cycle after write, abort has no effect.
REQ-044 Assert reset_n=0 asynchronously mid-stream with 6 committed and 2 uncommitted -> outputs reach reset values immediately without a clock edge; subsequent traffic correct from index 0.

Source files
------------

// File: rtl/sd_fifo_cmt.sv
// sd_fifo_cmt: single-clock FIFO with a commit/abort write side.
// Writes land in an uncommitted region [cmt_ptr, wr_ptr). A commit makes that
// region readable and an abort rolls wr_ptr back to cmt_ptr. Reads consume
// [rd_ptr, cmt_ptr). Separate occupancy counters resolve full/empty, so
// depth does not have to be a power of two.
module sd_fifo_cmt #(
    parameter int unsigned width       = 8,
    parameter int unsigned depth       = 12,
    parameter int unsigned commit_mode = 1,
    parameter int unsigned af_level    = depth - 2,
    parameter int unsigned ae_level    = 1,
    parameter int unsigned usz         = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    input  logic             c_commit,
    input  logic             c_abort,
    output logic [usz-1:0]   c_usage,
    output logic             almost_full,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [width-1:0] p_data,
    output logic [usz-1:0]   p_usage,
    output logic             almost_empty
);

    localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(depth - 1);

    logic [width-1:0] mem_q [depth];

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  cmt_ptr_q, cmt_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [usz-1:0] c_usage_q, c_usage_d;
    logic [usz-1:0] p_usage_q, p_usage_d;

    logic           wr_en;
    logic           rd_en;
    logic           abort_en;
    logic           commit_en;
    logic           mem_we;
    logic [usz-1:0] p_after_rd;

    // Pointer increment with wrap at depth-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // Handshake and status outputs depend only on registered counts.
    assign c_drdy       = (c_usage_q < usz'(depth));
    assign p_srdy       = (p_usage_q != '0);
    assign almost_full  = (c_usage_q >= usz'(af_level));
    assign almost_empty = (p_usage_q <= usz'(ae_level));
    assign c_usage      = c_usage_q;
    assign p_usage      = p_usage_q;
    assign p_data       = mem_q[rd_ptr_q];

    // Next-state for pointers and counters; abort takes priority over commit.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        cmt_ptr_d  = cmt_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        c_usage_d  = c_usage_q;
        p_usage_d  = p_usage_q;

        wr_en      = c_srdy & c_drdy;
        rd_en      = p_srdy & p_drdy;
        abort_en   = (commit_mode != 0) & c_abort;
        commit_en  = (commit_mode == 0) | c_commit;
        mem_we     = wr_en & ~abort_en;
        p_after_rd = p_usage_q - usz'(rd_en);

        if (rd_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (abort_en) begin
            // Only committed data survives; a same-cycle write is dropped.
            wr_ptr_d  = cmt_ptr_q;
            c_usage_d = p_after_rd;
            p_usage_d = p_after_rd;
        end else begin
            if (wr_en) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            c_usage_d = c_usage_q + usz'(wr_en) - usz'(rd_en);
            if (commit_en) begin
                // Commit includes a word written in the same cycle.
                cmt_ptr_d = wr_ptr_d;
                p_usage_d = c_usage_d;
            end else begin
                p_usage_d = p_after_rd;
            end
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            rd_ptr_q  <= '0;
            c_usage_q <= '0;
            p_usage_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            c_usage_q <= c_usage_d;
            p_usage_q <= p_usage_d;
        end
    end

    // Storage array; contents are never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= c_data;
        end
    end

endmodule

// File: tb/tb_sd_fifo_cmt.sv
// Bench for sd_fifo_cmt: a commit-mode instance under directed and random
// traffic, plus a commit_mode=0 instance under random traffic, both compared
// every cycle against queue-based models.
module tb_sd_fifo_cmt;

    localparam int D  = 12;
    localparam int AF = D - 2;
    localparam int AE = 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Commit-mode instance signals.
    logic       c_srdy, c_drdy, c_commit, c_abort, almost_full;
    logic [7:0] c_data, p_data;
    logic [3:0] c_usage, p_usage;
    logic       p_srdy, p_drdy, almost_empty;

    // Immediate-commit instance signals.
    logic       z_srdy, z_cdrdy, z_commit, z_abort, z_af;
    logic [7:0] z_cdata, z_pdata;
    logic [3:0] z_cusage, z_pusage;
    logic       z_psrdy, z_pdrdy, z_ae;

    sd_fifo_cmt #(.width(8), .depth(D), .commit_mode(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
        .c_commit(c_commit), .c_abort(c_abort),
        .c_usage(c_usage), .almost_full(almost_full),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data),
        .p_usage(p_usage), .almost_empty(almost_empty)
    );

    sd_fifo_cmt #(.width(8), .depth(D), .commit_mode(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .c_srdy(z_srdy), .c_drdy(z_cdrdy), .c_data(z_cdata),
        .c_commit(z_commit), .c_abort(z_abort),
        .c_usage(z_cusage), .almost_full(z_af),
        .p_srdy(z_psrdy), .p_drdy(z_pdrdy), .p_data(z_pdata),
        .p_usage(z_pusage), .almost_empty(z_ae)
    );

    int total = 0;
    int bad   = 0;

    // Reference contents: committed (pq), uncommitted (uq), mode-0 FIFO (zq).
    logic [7:0] pq[$];
    logic [7:0] uq[$];
    logic [7:0] zq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int cu;
        int pu;
        int zu;
        cu = pq.size() + uq.size();
        pu = pq.size();
        zu = zq.size();
        chk("c_usage", 32'(c_usage), cu);
        chk("p_usage", 32'(p_usage), pu);
        chk("c_drdy", 32'(c_drdy), 32'(cu < D));
        chk("p_srdy", 32'(p_srdy), 32'(pu != 0));
        chk("almost_full", 32'(almost_full), 32'(cu >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(pu <= AE));
        if (pu != 0) chk("p_data", 32'(p_data), 32'(pq[0]));
        chk("m0_c_usage", 32'(z_cusage), zu);
        chk("m0_p_usage", 32'(z_pusage), zu);
        chk("m0_c_drdy", 32'(z_cdrdy), 32'(zu < D));
        chk("m0_p_srdy", 32'(z_psrdy), 32'(zu != 0));
        chk("m0_almost_full", 32'(z_af), 32'(zu >= AF));
        chk("m0_almost_empty", 32'(z_ae), 32'(zu <= AE));
        if (zu != 0) chk("m0_p_data", 32'(z_pdata), 32'(zq[0]));
    endtask

    task automatic rand_m0();
        z_srdy   = 1'($urandom);
        z_cdata  = 8'($urandom);
        z_commit = 1'($urandom);
        z_abort  = 1'($urandom);
        z_pdrdy  = 1'($urandom);
    endtask

    // One clock: check outputs mid-cycle, then advance the models at the edge.
    task automatic cyc();
        bit w;
        bit r;
        bit zw;
        bit zr;
        @(negedge clk);
        #1;
        check_all();
        w  = c_srdy && ((pq.size() + uq.size()) < D);
        r  = p_drdy && (pq.size() != 0);
        zw = z_srdy && (zq.size() < D);
        zr = z_pdrdy && (zq.size() != 0);
        @(posedge clk);
        if (!reset_n) begin
            pq.delete(); uq.delete(); zq.delete();
        end else begin
            if (r) void'(pq.pop_front());
            if (c_abort) begin
                uq.delete();
            end else begin
                if (w) uq.push_back(c_data);
                if (c_commit) begin
                    foreach (uq[i]) pq.push_back(uq[i]);
                    uq.delete();
                end
            end
            if (zr) void'(zq.pop_front());
            if (zw) zq.push_back(z_cdata);
        end
        #1;
        rand_m0();
    endtask

    task automatic idle();
        c_srdy = 1'b0; c_commit = 1'b0; c_abort = 1'b0; p_drdy = 1'b0;
        c_data = 8'($urandom);
    endtask

    task automatic wr(input bit cm, input bit ab);
        idle();
        c_srdy = 1'b1; c_data = 8'($urandom); c_commit = cm; c_abort = ab;
        cyc();
    endtask

    task automatic drain();
        for (int k = 0; k < 3 * D && (pq.size() != 0); k++) begin
            idle(); p_drdy = 1'b1;
            cyc();
        end
        idle();
        cyc();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        rand_m0();
        cyc();
        cyc();
        #2 reset_n = 1'b1;
        cyc();

        // Five uncommitted words stay invisible until a standalone commit.
        repeat (5) wr(1'b0, 1'b0);
        idle(); cyc();
        idle(); c_commit = 1'b1; cyc();
        idle(); cyc();
        drain();

        // Commit three, then abort four more together with a fifth write.
        wr(1'b0, 1'b0); wr(1'b0, 1'b0); wr(1'b1, 1'b0);
        repeat (4) wr(1'b0, 1'b0);
        wr(1'b0, 1'b1);
        idle(); cyc();
        drain();

        // Commit and abort together: abort wins.
        wr(1'b0, 1'b0); wr(1'b0, 1'b0);
        idle(); c_commit = 1'b1; c_abort = 1'b1; cyc();
        idle(); cyc();

        // Fill uncommitted (extra attempt blocked), commit idle, full read+write.
        repeat (D + 1) wr(1'b0, 1'b0);
        idle(); c_commit = 1'b1; cyc();
        idle(); c_srdy = 1'b1; p_drdy = 1'b1; cyc();
        idle(); cyc();
        idle(); c_abort = 1'b1; cyc();
        drain();

        // Long stream, commit every fourth word, random concurrent reads.
        for (int i = 0; i < 40; i++) begin
            idle();
            c_srdy = 1'b1; c_data = 8'(i); c_commit = (i % 4 == 3);
            p_drdy = 1'($urandom_range(0, 3) != 0);
            cyc();
        end
        drain();

        // Fully random traffic with occasional aborts.
        for (int i = 0; i < 300; i++) begin
            c_srdy   = 1'($urandom);
            c_data   = 8'($urandom);
            c_commit = ($urandom_range(0, 3) == 0);
            c_abort  = ($urandom_range(0, 9) == 0);
            p_drdy   = 1'($urandom);
            cyc();
        end
        drain();

        // Asynchronous reset with six committed and two uncommitted words.
        repeat (5) wr(1'b0, 1'b0);
        wr(1'b1, 1'b0);
        wr(1'b0, 1'b0); wr(1'b0, 1'b0);
        idle();
        #2 reset_n = 1'b0;
        #1;
        pq.delete(); uq.delete(); zq.delete();
        check_all();
        cyc();
        #2 reset_n = 1'b1;
        wr(1'b0, 1'b0); wr(1'b0, 1'b0); wr(1'b1, 1'b0);
        idle(); cyc();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
